// File: rtl/ccff_loader_pkg.sv
// ----------------------------------------------------------------------------
// ccff_loader_pkg
// Shared definitions for the configuration-chain loader:
//   state_e          FSM state encoding (IDLE, LOAD, FLUSH, PULSE, CHECK)
//   MODE_LOAD        start mode selecting a bitstream load
//   MODE_PULSE_TEST  start mode selecting the chain integrity test
//   cnt_width()      width of the internal counters for a given chain length
// ----------------------------------------------------------------------------
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_PULSE = 3'd3,
        ST_CHECK = 3'd4
    } state_e;

    localparam logic MODE_LOAD       = 1'b0;
    localparam logic MODE_PULSE_TEST = 1'b1;

    // Wide enough for the longest operation (flush + pulse + check) with
    // headroom, so no counter can wrap inside a single operation.
    function automatic int cnt_width(input int chain_len);
        return $clog2(2 * chain_len + 4);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// ----------------------------------------------------------------------------
// ccff_word_serializer
// Turns accepted bitstream words into per-chain serial bits, MSB first.
// One holding register decouples the stream handshake from the per-chain
// shift registers so that words follow each other without a bubble.
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   en       in   1 while the loader is in LOAD; 0 empties all buffers
//   s_valid  in   word valid
//   s_ready  out  holding register empty and the word quota not reached
//   s_data   in   NUM_CHAINS x WORD_BITS word, chain c at [c*WORD_BITS +: WORD_BITS]
//   shift    out  a bit is available for every chain this cycle
//   head     out  current MSB of each chain's shift register (0 when stalled)
// ----------------------------------------------------------------------------
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS = 1,
    parameter int CHAIN_LEN  = 29696,
    parameter int WORD_BITS  = 32,
    parameter int CNT_W      = cnt_width(CHAIN_LEN)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_CHAINS*WORD_BITS-1:0] s_data,
    output logic                            shift,
    output logic [NUM_CHAINS-1:0]           head
);

    localparam int              TOTAL_W   = NUM_CHAINS * WORD_BITS;
    localparam logic [CNT_W-1:0] NUM_WORDS = CNT_W'(CHAIN_LEN / WORD_BITS);
    localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [TOTAL_W-1:0] hold_q, hold_d;
    logic [TOTAL_W-1:0] sr_q, sr_d;
    logic               hold_full_q, hold_full_d;
    logic [CNT_W-1:0]   bits_q, bits_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic               accept;

    always_comb begin
        s_ready     = en && !hold_full_q && (words_q < NUM_WORDS);
        accept      = s_valid && s_ready;
        shift       = en && (bits_q != '0);

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sr_d        = sr_q;
        bits_d      = bits_q;
        words_d     = words_q;
        head        = '0;

        for (int c = 0; c < NUM_CHAINS; c++) begin
            head[c] = shift && sr_q[c*WORD_BITS + WORD_BITS-1];
        end

        if (accept) begin
            hold_d      = s_data;
            hold_full_d = 1'b1;
            words_d     = words_q + ONE;
        end

        if (shift) begin
            for (int c = 0; c < NUM_CHAINS; c++) begin
                sr_d[c*WORD_BITS +: WORD_BITS] = {sr_q[c*WORD_BITS +: WORD_BITS-1], 1'b0};
            end
            bits_d = bits_q - ONE;
        end

        // Refill when the shift register is empty or emits its last bit
        // this cycle; the refilled word shifts from the next cycle on.
        if (hold_full_q && (bits_q <= ONE)) begin
            sr_d        = hold_q;
            bits_d      = WORD_CNT;
            hold_full_d = 1'b0;
        end

        // Leaving LOAD (done, abort, idle) discards whatever is buffered.
        if (!en) begin
            hold_full_d = 1'b0;
            bits_d      = '0;
            words_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            bits_q      <= '0;
            words_q     <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            bits_q      <= bits_d;
            words_q     <= words_d;
        end
    end

    // Data storage needs no reset: it is only observed through bits_q.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
        sr_q   <= sr_d;
    end

endmodule

// File: rtl/ccff_loader.sv
// ----------------------------------------------------------------------------
// ccff_loader
// Loads a bitstream into NUM_CHAINS parallel configuration flop chains, or
// runs an integrity test that flushes the chains, injects a single 1 and
// checks that it arrives at each tail after exactly CHAIN_LEN shifts.
//   prog_clk    in   clock (rising edge)
//   prog_reset  in   synchronous active-high reset
//   start       in   request, sampled only in IDLE
//   mode        in   sampled with start: 0 load, 1 pulse test
//   abort       in   return to IDLE from any busy state
//   s_valid     in   / s_ready out / s_data in : bitstream word stream
//   ccff_head   out  serial data into each chain head
//   ccff_tail   in   serial data from each chain tail
//   shift_en    out  chains advance one bit per cycle while 1
//   busy        out  not IDLE
//   done        out  operation finished (pulse after load, held after test)
//   error       out  OR of err_chain at the end of the test
//   err_chain   out  sticky per-chain test failure mask
// ----------------------------------------------------------------------------
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS = 1,
    parameter int CHAIN_LEN  = 29696,
    parameter int WORD_BITS  = 32
) (
    input  logic                            prog_clk,
    input  logic                            prog_reset,
    input  logic                            start,
    input  logic                            mode,
    input  logic                            abort,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_CHAINS*WORD_BITS-1:0] s_data,
    output logic [NUM_CHAINS-1:0]           ccff_head,
    input  logic [NUM_CHAINS-1:0]           ccff_tail,
    output logic                            shift_en,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [NUM_CHAINS-1:0]           err_chain
);

    localparam int               CNT_W      = cnt_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CHECK = CNT_W'(CHAIN_LEN + 2);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  done_keep_q, done_keep_d;
    logic                  error_q, error_d;
    logic [NUM_CHAINS-1:0] err_chain_q, err_chain_d;

    logic                  ser_en;
    logic                  ser_ready;
    logic                  ser_shift;
    logic [NUM_CHAINS-1:0] ser_head;
    logic                  shift_int;
    logic [NUM_CHAINS-1:0] head_int;
    logic                  tail_exp;

    assign ser_en = (state_q == ST_LOAD) && !prog_reset;

    ccff_word_serializer #(
        .NUM_CHAINS (NUM_CHAINS),
        .CHAIN_LEN  (CHAIN_LEN),
        .WORD_BITS  (WORD_BITS),
        .CNT_W      (CNT_W)
    ) u_ser (
        .clk     (prog_clk),
        .rst     (prog_reset),
        .en      (ser_en),
        .s_valid (s_valid),
        .s_ready (ser_ready),
        .s_data  (s_data),
        .shift   (ser_shift),
        .head    (ser_head)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_chain_d = err_chain_q;
        error_d     = error_q;
        // A load-done lasts one cycle; a test-done is held until next start.
        done_d      = done_q && done_keep_q;
        done_keep_d = done_keep_q;
        shift_int   = 1'b0;
        head_int    = '0;
        // cnt_q counts completed CHECK cycles, so cycle k has cnt_q = k-1.
        tail_exp    = (cnt_q == LAST_SHIFT);

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = (mode == MODE_PULSE_TEST) ? ST_FLUSH : ST_LOAD;
                    cnt_d       = '0;
                    err_chain_d = '0;
                    error_d     = 1'b0;
                    done_d      = 1'b0;
                    done_keep_d = 1'b0;
                end
            end
            ST_LOAD: begin
                shift_int = ser_shift;
                head_int  = ser_head;
                if (ser_shift) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == LAST_SHIFT) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                shift_int = 1'b1;
                cnt_d     = cnt_q + ONE;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end
            end
            ST_PULSE: begin
                shift_int = 1'b1;
                head_int  = '1;
                state_d   = ST_CHECK;
                cnt_d     = '0;
            end
            ST_CHECK: begin
                shift_int = 1'b1;
                // Case inequality so an X/Z tail also counts as a failure.
                for (int c = 0; c < NUM_CHAINS; c++) begin
                    if (ccff_tail[c] !== tail_exp) begin
                        err_chain_d[c] = 1'b1;
                    end
                end
                cnt_d = cnt_q + ONE;
                if (cnt_q == LAST_CHECK) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    done_d      = 1'b1;
                    done_keep_d = 1'b1;
                    error_d     = |err_chain_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort leaves the previous test verdict untouched and never
        // reports completion.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            done_d      = 1'b0;
            done_keep_d = 1'b0;
            err_chain_d = err_chain_q;
            error_d     = error_q;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            done_keep_q <= 1'b0;
            error_q     <= 1'b0;
            err_chain_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            done_keep_q <= done_keep_d;
            error_q     <= error_d;
            err_chain_q <= err_chain_d;
        end
    end

    // Outputs are forced low while reset is asserted, not only after it.
    assign s_ready   = ser_ready && !prog_reset;
    assign shift_en  = shift_int && !prog_reset;
    assign ccff_head = head_int & {NUM_CHAINS{!prog_reset}};
    assign busy      = (state_q != ST_IDLE) && !prog_reset;
    assign done      = done_q && !prog_reset;
    assign error     = error_q && !prog_reset;
    assign err_chain = err_chain_q & {NUM_CHAINS{!prog_reset}};

endmodule
